dispatch_nway: RTL and testbench

DISPATCH_NWAY -- requirements
Module: dispatch_nway

---
 rtl/dispatch_nway.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_dispatch_nway.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_nway.sv
// -----------------------------------------------------------------------------
// dispatch_nway
//
// Purpose
//   Holds one renamed instruction group and steers each instruction to its
//   issue queue (ALU_NUM ALU queues, one MDU queue, one LSU queue). Queues
//   drain independently, so a group may leave over several cycles. Source
//   operands still waiting for a producer are woken up by the CDB while held,
//   and the outputs bypass a same-cycle CDB match.
//
// Optional feature
//   DISPATCH_STALL_CNT_EN : when defined, stall_cnt_o counts HOLD cycles in
//                           which no queue handshake happens (saturating).
//                           When undefined, stall_cnt_o is tied to zero.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   flush_i                       drop the held group and any group offered
//   in_valid_i / in_ready_o       group handshake from rename
//   in_inst_valid_i [DW]          per-slot instruction valid
//   in_type_i       [DW][2]       0 ALU, 1 MDU, 2 LSU, 3 none (ROB only)
//   in_preg_i, in_wreg_i          destination preg and write enable
//   in_src_preg_i/_data_i/_valid_i  2 operands per instruction
//   cdb_valid_i/_preg_i/_data_i   write-back broadcasts
//   q_valid_o, q_ready_i          per-queue handshake
//   q_choose_o      [Q][DW]       which group instructions belong to queue q
//   q_data_o, q_data_valid_o      operands, shared by all queues
//   rob_alloc_o     [DW]          pulse per valid instruction accepted
//   stall_cnt_o     [32]          dispatch stall counter
// -----------------------------------------------------------------------------
module dispatch_nway #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int ALU_NUM        = 2,
    parameter int CDB_NUM        = 2,
    parameter int DATA_W         = 32,
    parameter int PREG_W         = 6
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           flush_i,
    input  logic                                           in_valid_i,
    output logic                                           in_ready_o,
    input  logic [DISPATCH_WIDTH-1:0]                      in_inst_valid_i,
    input  logic [DISPATCH_WIDTH-1:0][1:0]                 in_type_i,
    input  logic [DISPATCH_WIDTH-1:0][PREG_W-1:0]          in_preg_i,
    input  logic [DISPATCH_WIDTH-1:0]                      in_wreg_i,
    input  logic [2*DISPATCH_WIDTH-1:0][PREG_W-1:0]        in_src_preg_i,
    input  logic [2*DISPATCH_WIDTH-1:0][DATA_W-1:0]        in_src_data_i,
    input  logic [2*DISPATCH_WIDTH-1:0]                    in_src_valid_i,
    input  logic [CDB_NUM-1:0]                             cdb_valid_i,
    input  logic [CDB_NUM-1:0][PREG_W-1:0]                 cdb_preg_i,
    input  logic [CDB_NUM-1:0][DATA_W-1:0]                 cdb_data_i,
    output logic [ALU_NUM+1:0]                             q_valid_o,
    input  logic [ALU_NUM+1:0]                             q_ready_i,
    output logic [ALU_NUM+1:0][DISPATCH_WIDTH-1:0]         q_choose_o,
    output logic [2*DISPATCH_WIDTH-1:0][DATA_W-1:0]        q_data_o,
    output logic [2*DISPATCH_WIDTH-1:0]                    q_data_valid_o,
    output logic [DISPATCH_WIDTH-1:0]                      rob_alloc_o,
    output logic [31:0]                                    stall_cnt_o
);

    localparam int DW  = DISPATCH_WIDTH;
    localparam int OPS = 2 * DISPATCH_WIDTH;
    localparam int Q   = ALU_NUM + 2;
    localparam int QW  = (Q > 1) ? $clog2(Q) : 1;
    localparam int ASW = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;

    typedef enum logic [1:0] {
        UNIT_ALU  = 2'd0,
        UNIT_MDU  = 2'd1,
        UNIT_LSU  = 2'd2,
        UNIT_NONE = 2'd3
    } unit_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } cdb_hit_t;

    // Queue index for one instruction. ALU instructions are spread over the
    // ALU queues by the low bits of their destination preg.
    function automatic logic [QW-1:0] steer(input logic [1:0] unit,
                                            input logic [PREG_W-1:0] preg);
        logic [QW-1:0] idx;
        idx = '0;
        case (unit_e'(unit))
            UNIT_ALU: idx = (ALU_NUM > 1) ? QW'(preg[ASW-1:0]) : '0;
            UNIT_MDU: idx = QW'(ALU_NUM);
            UNIT_LSU: idx = QW'(ALU_NUM + 1);
            default:  idx = '0;
        endcase
        return idx;
    endfunction

    // Scan from the highest CDB index down so the lowest matching index is
    // the last one written and therefore wins on duplicates.
    function automatic cdb_hit_t cdb_match(input logic [PREG_W-1:0] preg,
                                           input logic [CDB_NUM-1:0] v,
                                           input logic [CDB_NUM-1:0][PREG_W-1:0] p,
                                           input logic [CDB_NUM-1:0][DATA_W-1:0] d);
        cdb_hit_t r;
        r = '0;
        for (int c = CDB_NUM - 1; c >= 0; c--) begin
            if (v[c] && (p[c] == preg)) begin
                r.hit  = 1'b1;
                r.data = d[c];
            end
        end
        return r;
    endfunction

    // Held group
    state_e                      state_q, state_d;
    logic [DW-1:0]               pending_q, pending_d;
    logic [DW-1:0][1:0]          unit_q, unit_d;
    logic [DW-1:0][PREG_W-1:0]   dst_preg_q, dst_preg_d;
    logic [OPS-1:0][PREG_W-1:0]  src_preg_q, src_preg_d;
    logic [OPS-1:0][DATA_W-1:0]  src_data_q, src_data_d;
    logic [OPS-1:0]              src_valid_q, src_valid_d;

    // Steering / handshake
    logic [Q-1:0][DW-1:0]        choose;
    logic [Q-1:0]                q_valid;
    logic [DW-1:0]               deliver;
    logic [DW-1:0]               pending_left;
    logic                        in_ready;
    logic                        accept;

    // Operand merge
    cdb_hit_t                    hold_hit [OPS];
    cdb_hit_t                    in_hit   [OPS];
    logic [OPS-1:0][DATA_W-1:0]  merged_data;
    logic [OPS-1:0]              merged_valid;

    // -------------------------------------------------------------------------
    // Steering and per-queue handshake
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the top of
    // the block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        choose  = '0;
        q_valid = '0;
        deliver = '0;
        for (int q = 0; q < Q; q++) begin
            for (int i = 0; i < DW; i++) begin
                choose[q][i] = (state_q == S_HOLD) && pending_q[i] &&
                               (steer(unit_q[i], dst_preg_q[i]) == QW'(q));
            end
            q_valid[q] = |choose[q];
            if (q_valid[q] && q_ready_i[q]) begin
                deliver = deliver | choose[q];
            end
        end
    end

    // A new group may enter while the old one finishes leaving this cycle.
    assign pending_left = pending_q & ~deliver;
    assign in_ready     = !flush_i && ((state_q == S_EMPTY) || (pending_left == '0));
    assign accept       = in_valid_i && in_ready;

    // -------------------------------------------------------------------------
    // Operand wakeup / bypass
    // -------------------------------------------------------------------------
    always_comb begin
        merged_data  = src_data_q;
        merged_valid = src_valid_q;
        for (int k = 0; k < OPS; k++) begin
            hold_hit[k] = cdb_match(src_preg_q[k], cdb_valid_i, cdb_preg_i, cdb_data_i);
            in_hit[k]   = cdb_match(in_src_preg_i[k], cdb_valid_i, cdb_preg_i, cdb_data_i);
            if (!src_valid_q[k] && hold_hit[k].hit) begin
                merged_data[k]  = hold_hit[k].data;
                merged_valid[k] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_left;
        unit_d      = unit_q;
        dst_preg_d  = dst_preg_q;
        src_preg_d  = src_preg_q;
        src_data_d  = merged_data;
        src_valid_d = merged_valid;

        if (flush_i) begin
            pending_d = '0;
            state_d   = S_EMPTY;
        end else if (accept) begin
            for (int i = 0; i < DW; i++) begin
                unit_d[i]     = in_type_i[i];
                dst_preg_d[i] = in_preg_i[i];
                pending_d[i]  = in_inst_valid_i[i] && (unit_e'(in_type_i[i]) != UNIT_NONE);
            end
            for (int k = 0; k < OPS; k++) begin
                src_preg_d[k]  = in_src_preg_i[k];
                src_data_d[k]  = in_src_data_i[k];
                src_valid_d[k] = in_src_valid_i[k];
                // A broadcast arriving while the operand is in flight would
                // otherwise be missed for good.
                if (!in_src_valid_i[k] && in_hit[k].hit) begin
                    src_data_d[k]  = in_hit[k].data;
                    src_valid_d[k] = 1'b1;
                end
                // An earlier instruction of this group produces this preg, so
                // whatever value rename supplied is stale.
                for (int j = 0; j < DW; j++) begin
                    if ((j < k / 2) && in_inst_valid_i[j] && in_wreg_i[j] &&
                        (in_preg_i[j] == in_src_preg_i[k])) begin
                        src_valid_d[k] = 1'b0;
                    end
                end
            end
            state_d = (pending_d != '0) ? S_HOLD : S_EMPTY;
        end else begin
            state_d = (pending_left != '0) ? S_HOLD : S_EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    // NOTE: the held operand storage is reset along with the control state so
    // the operand outputs read back as zero/invalid straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            pending_q   <= '0;
            unit_q      <= '0;
            dst_preg_q  <= '0;
            src_preg_q  <= '0;
            src_data_q  <= '0;
            src_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            unit_q      <= unit_d;
            dst_preg_q  <= dst_preg_d;
            src_preg_q  <= src_preg_d;
            src_data_q  <= src_data_d;
            src_valid_q <= src_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready_o     = in_ready;
    assign q_valid_o      = q_valid;
    assign q_choose_o     = choose;
    assign q_data_o       = merged_data;
    assign q_data_valid_o = merged_valid;
    assign rob_alloc_o    = accept ? in_inst_valid_i : '0;

`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_HOLD) && ((q_valid & q_ready_i) == '0) &&
            (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dispatch_nway.sv
// -----------------------------------------------------------------------------
// tb_dispatch_nway
//
// Self-checking bench for dispatch_nway (default parameters: DW=2, ALU_NUM=2,
// CDB_NUM=2). Queue map: 0,1 ALU, 2 MDU, 3 LSU. q_choose_o is viewed as an
// 8-bit vector, bits [2q+1:2q] belonging to queue q, bit i = instruction i.
// -----------------------------------------------------------------------------
module tb_dispatch_nway;

    localparam int DW     = 2;
    localparam int ALU_N  = 2;
    localparam int CDB_N  = 2;
    localparam int DATA_W = 32;
    localparam int PREG_W = 6;
    localparam int Q      = ALU_N + 2;
    localparam int OPS    = 2 * DW;

    localparam logic [1:0] T_ALU  = 2'd0;
    localparam logic [1:0] T_MDU  = 2'd1;
    localparam logic [1:0] T_LSU  = 2'd2;
    localparam logic [1:0] T_NONE = 2'd3;

`ifdef DISPATCH_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic                              clk;
    logic                              rst_n;
    logic                              flush;
    logic                              in_valid;
    logic                              in_ready;
    logic [DW-1:0]                     in_inst_valid;
    logic [DW-1:0][1:0]                in_type;
    logic [DW-1:0][PREG_W-1:0]         in_preg;
    logic [DW-1:0]                     in_wreg;
    logic [OPS-1:0][PREG_W-1:0]        in_src_preg;
    logic [OPS-1:0][DATA_W-1:0]        in_src_data;
    logic [OPS-1:0]                    in_src_valid;
    logic [CDB_N-1:0]                  cdb_valid;
    logic [CDB_N-1:0][PREG_W-1:0]      cdb_preg;
    logic [CDB_N-1:0][DATA_W-1:0]      cdb_data;
    logic [Q-1:0]                      q_valid;
    logic [Q-1:0]                      q_ready;
    logic [Q-1:0][DW-1:0]              q_choose;
    logic [OPS-1:0][DATA_W-1:0]        q_data;
    logic [OPS-1:0]                    q_data_valid;
    logic [DW-1:0]                     rob_alloc;
    logic [31:0]                       stall_cnt;

    dispatch_nway #(
        .DISPATCH_WIDTH (DW),
        .ALU_NUM        (ALU_N),
        .CDB_NUM        (CDB_N),
        .DATA_W         (DATA_W),
        .PREG_W         (PREG_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_inst_valid_i (in_inst_valid),
        .in_type_i       (in_type),
        .in_preg_i       (in_preg),
        .in_wreg_i       (in_wreg),
        .in_src_preg_i   (in_src_preg),
        .in_src_data_i   (in_src_data),
        .in_src_valid_i  (in_src_valid),
        .cdb_valid_i     (cdb_valid),
        .cdb_preg_i      (cdb_preg),
        .cdb_data_i      (cdb_data),
        .q_valid_o       (q_valid),
        .q_ready_i       (q_ready),
        .q_choose_o      (q_choose),
        .q_data_o        (q_data),
        .q_data_valid_o  (q_data_valid),
        .rob_alloc_o     (rob_alloc),
        .stall_cnt_o     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Table of groups applied back to back with every queue ready.
    typedef struct {
        logic [1:0]        iv;
        logic [1:0]        t0;
        logic [1:0]        t1;
        logic [PREG_W-1:0] p0;
        logic [PREG_W-1:0] p1;
        logic [3:0]        exp_valid;
        logic [7:0]        exp_choose;
        logic [1:0]        exp_rob;
    } vec_t;

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  choose;
        logic [31:0] data0;
        int          idx;
    } sb_t;

    vec_t vecs [8];
    sb_t  sb [$];
    sb_t  e;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_group(input logic [1:0] iv, input logic [1:0] t0, input logic [1:0] t1,
                               input logic [PREG_W-1:0] p0, input logic [PREG_W-1:0] p1,
                               input logic [1:0] wreg);
        in_valid      = 1'b1;
        in_inst_valid = iv;
        in_type[0]    = t0;
        in_type[1]    = t1;
        in_preg[0]    = p0;
        in_preg[1]    = p1;
        in_wreg       = wreg;
    endtask

    task automatic set_srcs(input logic [PREG_W-1:0] s0, input logic [PREG_W-1:0] s1,
                            input logic [PREG_W-1:0] s2, input logic [PREG_W-1:0] s3,
                            input logic [3:0] v, input logic [31:0] base);
        in_src_preg[0] = s0;
        in_src_preg[1] = s1;
        in_src_preg[2] = s2;
        in_src_preg[3] = s3;
        in_src_valid   = v;
        for (int k = 0; k < OPS; k++) begin
            in_src_data[k] = base + (32'(k) << 8);
        end
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_inst_valid = '0;
    endtask

    initial begin
        vecs[0] = '{2'b11, T_ALU,  T_ALU,  6'd4, 6'd5, 4'b0011, 8'h09, 2'b11};
        vecs[1] = '{2'b11, T_MDU,  T_LSU,  6'd0, 6'd0, 4'b1100, 8'h90, 2'b11};
        vecs[2] = '{2'b11, T_ALU,  T_ALU,  6'd3, 6'd7, 4'b0010, 8'h0C, 2'b11};
        vecs[3] = '{2'b11, T_NONE, T_ALU,  6'd1, 6'd6, 4'b0001, 8'h02, 2'b11};
        vecs[4] = '{2'b01, T_ALU,  T_ALU,  6'd1, 6'd2, 4'b0010, 8'h04, 2'b01};
        vecs[5] = '{2'b11, T_NONE, T_NONE, 6'd1, 6'd2, 4'b0000, 8'h00, 2'b11};
        vecs[6] = '{2'b11, T_LSU,  T_LSU,  6'd9, 6'd9, 4'b1000, 8'hC0, 2'b11};
        vecs[7] = '{2'b11, T_MDU,  T_ALU,  6'd0, 6'd2, 4'b0101, 8'h12, 2'b11};

        rst_n         = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_inst_valid = '0;
        in_type       = '0;
        in_preg       = '0;
        in_wreg       = '0;
        in_src_preg   = '0;
        in_src_data   = '0;
        in_src_valid  = '0;
        cdb_valid     = '0;
        cdb_preg      = '0;
        cdb_data      = '0;
        q_ready       = '1;

        // ---------------- Reset state ----------------
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_in_ready",   in_ready, 1);
        check("rst_q_valid",    q_valid, 0);
        check("rst_rob_alloc",  rob_alloc, 0);
        check("rst_stall_cnt",  stall_cnt, 0);
        check("rst_data_valid", q_data_valid, 0);
        check("rst_data0",      q_data[0], 0);
        cycle();

        // ---------------- Two ALUs, both ready ----------------
        set_srcs(6'd40, 6'd41, 6'd42, 6'd43, 4'hF, 32'h2000_0000);
        drive_group(2'b11, T_ALU, T_ALU, 6'd4, 6'd5, 2'b00);
        #1 check("alu2_rob", rob_alloc, 2'b11);
        cycle();
        idle();
        #1;
        check("alu2_q_valid", q_valid, 4'b0011);
        check("alu2_choose",  q_choose, 8'h09);
        cycle();
        check("alu2_empty_valid", q_valid, 0);
        check("alu2_empty_ready", in_ready, 1);

        // ---------------- Table, back to back, scoreboard ----------------
        for (int n = 0; n < 8; n++) begin
            set_srcs(6'd40, 6'd41, 6'd42, 6'd43, 4'hF, 32'h1000_0000 + 32'(n));
            drive_group(vecs[n].iv, vecs[n].t0, vecs[n].t1, vecs[n].p0, vecs[n].p1, 2'b00);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("tbl%0d_q_valid", e.idx), q_valid, e.valid);
                check($sformatf("tbl%0d_choose", e.idx), q_choose, e.choose);
                if (e.valid != 0) begin
                    check($sformatf("tbl%0d_data0", e.idx), q_data[0], e.data0);
                    check($sformatf("tbl%0d_dvalid", e.idx), q_data_valid, 4'hF);
                end
            end
            check($sformatf("tbl%0d_in_ready", n), in_ready, 1);
            check($sformatf("tbl%0d_rob", n), rob_alloc, vecs[n].exp_rob);
            sb.push_back('{vecs[n].exp_valid, vecs[n].exp_choose, 32'h1000_0000 + 32'(n), n});
            cycle();
        end
        idle();
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("tbl%0d_q_valid", e.idx), q_valid, e.valid);
            check($sformatf("tbl%0d_choose", e.idx), q_choose, e.choose);
        end
        check("sb_drained", sb.size(), 0);
        cycle();
        check("tbl_end_empty", q_valid, 0);

        // ---------------- Partial dispatch: LSU blocked 3 cycles ----------------
        set_srcs(6'd40, 6'd41, 6'd42, 6'd43, 4'hF, 32'h3000_0000);
        drive_group(2'b11, T_ALU, T_LSU, 6'd2, 6'd0, 2'b00);
        #1 check("part_accept_ready", in_ready, 1);
        cycle();
        idle();
        q_ready = 4'b0111;
        #1;
        check("part_c1_valid",  q_valid, 4'b1001);
        check("part_c1_choose", q_choose, 8'h81);
        check("part_c1_ready",  in_ready, 0);
        cycle();
        check("part_c2_valid",  q_valid, 4'b1000);
        check("part_c2_choose", q_choose, 8'h80);
        check("part_c2_ready",  in_ready, 0);
        cycle();
        drive_group(2'b11, T_ALU, T_ALU, 6'd0, 6'd1, 2'b00);
        #1;
        check("part_c3_valid", q_valid, 4'b1000);
        check("part_c3_ready", in_ready, 0);
        check("part_c3_rob",   rob_alloc, 0);
        cycle();
        idle();
        q_ready = 4'hF;
        #1;
        check("part_c4_valid", q_valid, 4'b1000);
        check("part_c4_ready", in_ready, 1);
        cycle();
        check("part_c5_valid", q_valid, 0);

        // ---------------- CDB wakeup / bypass ----------------
        q_ready = 4'b1110;
        set_srcs(6'd9, 6'd41, 6'd42, 6'd43, 4'b1110, 32'h4000_0000);
        drive_group(2'b11, T_ALU, T_NONE, 6'd0, 6'd0, 2'b00);
        #1 check("wk_rob", rob_alloc, 2'b11);
        cycle();
        idle();
        cdb_valid   = 2'b01;
        cdb_preg[0] = 6'd8;
        cdb_data[0] = 32'h0000_0055;
        #1;
        check("wk_c1_valid",  q_valid, 4'b0001);
        check("wk_c1_dvalid", q_data_valid, 4'b1110);
        cycle();
        cdb_valid   = 2'b11;
        cdb_preg[0] = 6'd9;
        cdb_preg[1] = 6'd9;
        cdb_data[0] = 32'hDEAD_BEEF;
        cdb_data[1] = 32'h1234_5678;
        #1;
        check("wk_bypass_data",  q_data[0], 32'hDEAD_BEEF);
        check("wk_bypass_valid", q_data_valid, 4'hF);
        cycle();
        cdb_valid = '0;
        #1;
        check("wk_hold_data",  q_data[0], 32'hDEAD_BEEF);
        check("wk_hold_valid", q_data_valid, 4'hF);
        check("wk_hold_q",     q_valid, 4'b0001);
        q_ready = 4'hF;
        cycle();
        check("wk_done", q_valid, 0);

        // ---------------- Intra-group dependency ----------------
        set_srcs(6'd7, 6'd1, 6'd7, 6'd10, 4'hF, 32'h5000_0000);
        drive_group(2'b11, T_ALU, T_ALU, 6'd7, 6'd8, 2'b01);
        cycle();
        idle();
        #1;
        check("dep_dvalid", q_data_valid, 4'b1011);
        check("dep_valid",  q_valid, 4'b0011);
        check("dep_choose", q_choose, 8'h06);
        cycle();
        set_srcs(6'd7, 6'd1, 6'd7, 6'd10, 4'hF, 32'h5100_0000);
        drive_group(2'b11, T_ALU, T_ALU, 6'd7, 6'd8, 2'b00);
        cycle();
        idle();
        #1 check("nodep_dvalid", q_data_valid, 4'hF);
        cycle();

        // ---------------- Flush during HOLD ----------------
        q_ready = '0;
        set_srcs(6'd40, 6'd41, 6'd42, 6'd43, 4'hF, 32'h6000_0000);
        drive_group(2'b11, T_ALU, T_MDU, 6'd4, 6'd0, 2'b00);
        cycle();
        flush = 1'b1;
        drive_group(2'b11, T_LSU, T_LSU, 6'd0, 6'd0, 2'b00);
        #1;
        check("fl_hold_valid", q_valid, 4'b0101);
        check("fl_ready",      in_ready, 0);
        check("fl_rob",        rob_alloc, 0);
        cycle();
        flush = 1'b0;
        idle();
        q_ready = 4'hF;
        #1;
        check("fl_next_valid", q_valid, 0);
        check("fl_next_rob",   rob_alloc, 0);
        check("fl_next_ready", in_ready, 1);
        cycle();
        check("fl_after_valid", q_valid, 0);

        // ---------------- Stall counter ----------------
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1 check("st_rst", stall_cnt, 0);
        q_ready = '0;
        drive_group(2'b11, T_ALU, T_ALU, 6'd0, 6'd0, 2'b00);
        cycle();
        idle();
        repeat (10) cycle();
        check("st_count",   stall_cnt, EXP_STALL);
        check("st_q_valid", q_valid, 4'b0001);
        q_ready = 4'hF;
        cycle();
        check("st_after_hs", stall_cnt, EXP_STALL);
        cycle();
        check("st_empty",    stall_cnt, EXP_STALL);

        // ---------------- Reset mid-HOLD ----------------
        q_ready = '0;
        drive_group(2'b11, T_MDU, T_LSU, 6'd0, 6'd0, 2'b00);
        cycle();
        idle();
        #1 check("rh_held", q_valid, 4'b1100);
        rst_n = 1'b0;
        #1 check("rh_in_reset", q_valid, 0);
        rst_n   = 1'b1;
        q_ready = 4'hF;
        #1;
        check("rh_valid", q_valid, 0);
        check("rh_stall", stall_cnt, 0);
        check("rh_ready", in_ready, 1);
        cycle();
        check("rh_next_valid", q_valid, 0);
        check("rh_next_rob",   rob_alloc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
